vmem_copy_fill: RTL

Video RAM block-move engine that sits directly upstream of VIDEO_RAM and drives its port B (we_b/addr_b/din_b, consuming dout_b). It performs register-triggered fill (constant byte over a range) and copy (range to range) operations so the CPU does not move video memory one byte at a time through port A. Port access is granted cycle by cycle by the bus arbiter.

---
 rtl/vmem_copy_fill_if.sv | 50 +++++
 rtl/vmem_copy_fill.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/vmem_copy_fill_if.sv
// ---------------------------------------------------------------------------
// vmem_copy_fill_if
// Groups the command/status and RAM port B signals of the video RAM
// block-move engine.
//
// Signals:
//   start     1       one-cycle request, ignored while busy
//   op        1       0 = fill, 1 = copy (sampled with start)
//   src_addr  ADDR_W  copy source base (sampled with start)
//   dst_addr  ADDR_W  destination base (sampled with start)
//   len       ADDR_W  byte count, 0 = no-op (sampled with start)
//   fill_val  DATA_W  fill byte (sampled with start)
//   busy      1       operation in progress
//   done      1       one-cycle completion pulse
//   grant     1       engine owns RAM port B this cycle
//   ram_we    1       to we_b
//   ram_addr  ADDR_W  to addr_b
//   ram_din   DATA_W  to din_b
//   ram_dout  DATA_W  from dout_b
//
// Modports: master = the engine, slave = the CPU / arbiter / RAM side.
// ---------------------------------------------------------------------------
interface vmem_copy_fill_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              start;
  logic              op;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [ADDR_W-1:0] len;
  logic [DATA_W-1:0] fill_val;
  logic              busy;
  logic              done;
  logic              grant;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  modport master (
    input  start, op, src_addr, dst_addr, len, fill_val, grant, ram_dout,
    output busy, done, ram_we, ram_addr, ram_din
  );

  modport slave (
    output start, op, src_addr, dst_addr, len, fill_val, grant, ram_dout,
    input  busy, done, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/vmem_copy_fill.sv
// ---------------------------------------------------------------------------
// vmem_copy_fill
// Video RAM block-move engine driving port B of VIDEO_RAM. Performs a fill
// (constant byte over a range) or a copy (range to range, overlap safe)
// triggered by a one-cycle start request.
//
// Ports:
//   clk          system clock (same clock as VIDEO_RAM)
//   rst          synchronous active-high reset, aborts any operation
//   bus          vmem_copy_fill_if.master: command, status, RAM port B
//   dbg_state_o  current FSM state encoding (IDLE=0 FILL=1 RD=2 HOLD=3
//                WR=4 FIN=5)
//
// Handshakes:
//   start/busy: a start pulse is accepted in any cycle where the engine is
//   not busy (IDLE or the FIN/done cycle); command fields are sampled in the
//   same cycle. While busy, start is ignored.
//   grant: the arbiter gives port B to the engine for the current cycle.
//   The engine only advances (and only asserts ram_we) in granted cycles;
//   an ungranted cycle leaves every register unchanged, except that an
//   ungranted HOLD cycle sends the FSM back to RD to redo the read.
// ---------------------------------------------------------------------------
module vmem_copy_fill #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  vmem_copy_fill_if.master    bus,
  output logic [2:0]          dbg_state_o
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_RD   = 3'd2,
    ST_HOLD = 3'd3,
    ST_WR   = 3'd4,
    ST_FIN  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              desc_q, desc_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;

  // Start-time decode: a copy toward higher addresses runs top-down so an
  // overlapping source is read before it is overwritten.
  logic              start_desc;
  logic [ADDR_W-1:0] start_src;
  logic [ADDR_W-1:0] start_dst;
  logic [ADDR_W-1:0] src_step;
  logic [ADDR_W-1:0] dst_step;
  logic              last_byte;

  assign start_desc = bus.op & (bus.dst_addr > bus.src_addr);
  assign start_src  = start_desc ? (bus.src_addr + bus.len - 1'b1) : bus.src_addr;
  assign start_dst  = start_desc ? (bus.dst_addr + bus.len - 1'b1) : bus.dst_addr;
  assign src_step   = desc_q ? (src_q - 1'b1) : (src_q + 1'b1);
  assign dst_step   = desc_q ? (dst_q - 1'b1) : (dst_q + 1'b1);
  assign last_byte  = (cnt_q == ADDR_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      desc_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      desc_q  <= desc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  // The bus registers (addr/din/we) are loaded on the edge that enters a
  // state, so they already describe the access of the state being executed.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    desc_d  = desc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    we_d    = we_q;
    addr_d  = addr_q;
    din_d   = din_q;

    case (state_q)
      ST_IDLE, ST_FIN: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        we_d    = 1'b0;
        if (bus.start) begin
          if (bus.len == '0) begin
            state_d = ST_FIN;
            done_d  = 1'b1;
          end else begin
            desc_d = start_desc;
            src_d  = start_src;
            dst_d  = start_dst;
            cnt_d  = bus.len;
            busy_d = 1'b1;
            if (!bus.op) begin
              state_d = ST_FILL;
              addr_d  = start_dst;
              din_d   = bus.fill_val;
              we_d    = 1'b1;
            end else begin
              state_d = ST_RD;
              addr_d  = start_src;
            end
          end
        end
      end

      ST_FILL: begin
        if (bus.grant) begin
          cnt_d = cnt_q - 1'b1;
          dst_d = dst_step;
          if (last_byte) begin
            state_d = ST_FIN;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            we_d    = 1'b0;
          end else begin
            addr_d = dst_step;
          end
        end
      end

      ST_RD: begin
        if (bus.grant) begin
          state_d = ST_HOLD;
        end
      end

      // ram_addr must still point at the source here: the RAM's bank mux
      // follows the live address while its data register holds the read.
      ST_HOLD: begin
        if (bus.grant) begin
          state_d = ST_WR;
          din_d   = bus.ram_dout;
          addr_d  = dst_q;
          we_d    = 1'b1;
        end else begin
          state_d = ST_RD;
        end
      end

      ST_WR: begin
        if (bus.grant) begin
          src_d = src_step;
          dst_d = dst_step;
          cnt_d = cnt_q - 1'b1;
          we_d  = 1'b0;
          if (last_byte) begin
            state_d = ST_FIN;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = ST_RD;
            addr_d  = src_step;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  // The write strobe is prepared a cycle ahead but only reaches the RAM in
  // a granted cycle; an ungranted FILL/WR cycle therefore never writes.
  assign bus.ram_we   = we_q & bus.grant;
  assign bus.ram_addr = addr_q;
  assign bus.ram_din  = din_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign dbg_state_o  = state_q;

endmodule
